// File: rtl/mips_multicycle_control.sv
// Multicycle control sequencer for the MIPS demo datapath; optional jump support under MIPS_JUMP_EN.
// Latency: lw 5, sw/R-type 4, beq/j 3, illegal 2 cycles; outputs are Moore decodes of the state register.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; mem_ready is ignored in every other state.
module mips_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;
  logic             retire;
  logic             funct_legal;
  logic [3:0]       funct_alu;

  // The zero flag only matters to the PC datapath via pc_write_cond, never to sequencing.
  logic unused_zero;
  assign unused_zero = zero;

  // R-type funct decode: ALU operation and legality.
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_AND;
    case (funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  // State, illegal pulse and retire counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_FETCH;
      illegal_q       <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      illegal_q       <= illegal_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Next-state, illegal-instruction and retire decode.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h00: begin
            if (funct_legal) begin
              state_d = S_RTEXE;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          6'h04: state_d = S_BRANCH;
`ifdef MIPS_JUMP_EN
          6'h02: state_d = S_JUMP;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_RTEXE:  state_d = S_RTWB;
      S_RTWB:   begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
`ifdef MIPS_JUMP_EN
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
`endif
      default:  state_d = S_FETCH;
    endcase
    retired_count_d = retired_count_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Moore output decode; everything is forced low while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_ctrl      = 4'd0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          alu_ctrl  = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          alu_ctrl  = ALU_ADD;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_ctrl  = ALU_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_RTEXE: begin
          alu_src_a = 1'b1;
          alu_ctrl  = funct_alu;
        end
        S_RTWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ctrl      = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
        end
`ifdef MIPS_JUMP_EN
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state         = state_q;
  assign illegal       = illegal_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: driver queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares state, control word, illegal flag and retire count.
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  pc_source, alu_src_b;
  logic [3:0]  alu_ctrl, state;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .state(state),
    .illegal(illegal), .retired_count(retired_count)
  );

  // Control word: {pc_write, pc_write_cond, pc_source[1:0], i_or_d, mem_read, mem_write,
  //                ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_ctrl[3:0]}
  logic [17:0] ctl;
  assign ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl};

  localparam logic [17:0] C_RST   = 18'b0_0_00_0_0_0_0_0_0_0_0_00_0000;
  localparam logic [17:0] C_FRDY  = 18'b1_0_00_0_1_0_1_0_0_0_0_01_0010;
  localparam logic [17:0] C_FWAIT = 18'b0_0_00_0_1_0_0_0_0_0_0_01_0010;
  localparam logic [17:0] C_DEC   = 18'b0_0_00_0_0_0_0_0_0_0_0_11_0010;
  localparam logic [17:0] C_MADR  = 18'b0_0_00_0_0_0_0_0_0_0_1_10_0010;
  localparam logic [17:0] C_MRD   = 18'b0_0_00_1_1_0_0_0_0_0_0_00_0000;
  localparam logic [17:0] C_MWB   = 18'b0_0_00_0_0_0_0_1_0_1_0_00_0000;
  localparam logic [17:0] C_MWR   = 18'b0_0_00_1_0_1_0_0_0_0_0_00_0000;
  localparam logic [17:0] C_RADD  = 18'b0_0_00_0_0_0_0_0_0_0_1_00_0010;
  localparam logic [17:0] C_RSUB  = 18'b0_0_00_0_0_0_0_0_0_0_1_00_0110;
  localparam logic [17:0] C_RWB   = 18'b0_0_00_0_0_0_0_1_1_0_0_00_0000;
  localparam logic [17:0] C_BR    = 18'b0_1_01_0_0_0_0_0_0_0_1_00_0110;
  localparam logic [17:0] C_JMP   = 18'b1_0_10_0_0_0_0_0_0_0_0_00_0000;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", {28'd0, state}, {28'd0, e.st});
        check("ctl", {14'd0, ctl}, {14'd0, e.ctl});
        check("illegal", {31'd0, illegal}, {31'd0, e.ill});
        check("retired_count", retired_count, e.cnt);
      end
    end
  end

  task automatic step(input logic mr, input logic [3:0] st, input logic [17:0] c,
                      input logic ill, input logic [31:0] cnt);
    exp_t e;
    mem_ready = mr;
    e.st = st; e.ctl = c; e.ill = ill; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] ir);
    opcode = ir[31:26];
    funct  = ir[5:0];
  endtask

`ifdef MIPS_JUMP_EN
  localparam logic        J_ILL = 1'b0;
  localparam logic [31:0] J_CNT = 32'd6;
`else
  localparam logic        J_ILL = 1'b1;
  localparam logic [31:0] J_CNT = 32'd5;
`endif

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(1, 0, C_RST, 0, 0);          // held in reset: everything low
    rst = 1'b0;

    load_ir(32'h00221820);            // add
    step(1, 0, C_FRDY, 0, 0);
    step(1, 1, C_DEC,  0, 0);
    step(1, 6, C_RADD, 0, 0);
    step(1, 7, C_RWB,  0, 0);

    load_ir(32'h00411822);            // sub
    step(1, 0, C_FRDY, 0, 1);
    step(1, 1, C_DEC,  0, 1);
    step(1, 6, C_RSUB, 0, 1);
    step(1, 7, C_RWB,  0, 1);

    load_ir(32'h8C240000);            // lw with two wait states
    step(1, 0, C_FRDY, 0, 2);
    step(1, 1, C_DEC,  0, 2);
    step(1, 2, C_MADR, 0, 2);
    step(0, 3, C_MRD,  0, 2);
    step(0, 3, C_MRD,  0, 2);
    step(1, 3, C_MRD,  0, 2);
    step(1, 4, C_MWB,  0, 2);

    load_ir(32'hAC010000);            // sw
    step(1, 0, C_FRDY, 0, 3);
    step(1, 1, C_DEC,  0, 3);
    step(1, 2, C_MADR, 0, 3);
    step(1, 5, C_MWR,  0, 3);

    load_ir(32'h10210001);            // beq, one fetch wait state
    zero = 1'b1;
    step(0, 0, C_FWAIT, 0, 4);
    step(1, 0, C_FRDY,  0, 4);
    step(1, 1, C_DEC,   0, 4);
    step(1, 8, C_BR,    0, 4);
    zero = 1'b0;

    load_ir(32'h00221821);            // bad funct
    step(1, 0, C_FRDY, 0, 5);
    step(1, 1, C_DEC,  0, 5);

    load_ir(32'h08000004);            // j
    step(1, 0, C_FRDY, 1, 5);         // illegal pulse from the bad funct
    step(1, 1, C_DEC,  0, 5);
`ifdef MIPS_JUMP_EN
    step(1, 9, C_JMP,  0, 5);
`endif

    load_ir(32'h8C240000);            // lw interrupted by reset
    step(1, 0, C_FRDY, J_ILL, J_CNT);
    step(1, 1, C_DEC,  0, J_CNT);
    step(1, 2, C_MADR, 0, J_CNT);
    step(0, 3, C_MRD,  0, J_CNT);
    rst = 1'b1;                       // asynchronous, mid-MEMRD
    step(1, 0, C_RST,  0, 0);
    rst = 1'b0;

    load_ir(32'h00221820);            // add after reset, counting from zero
    step(1, 0, C_FRDY, 0, 0);
    step(1, 1, C_DEC,  0, 0);
    step(1, 6, C_RADD, 0, 0);
    step(1, 7, C_RWB,  0, 0);
    step(0, 0, C_FWAIT, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle sequencer for the MIPS demo datapath. Decodes the fetched instruction and drives the enables and selects of the program counter, instruction register, register file, ALU, and the unified instruction/data memory port. Executes one instruction over 3–5 states. Stalls on a memory-ready handshake, and exposes a retired-instruction counter and an illegal-instruction flag for debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of `retired_count`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond` out 1: unconditional PC load, and PC load qualified by `zero`.
- `pc_source` out 2: PC mux select. 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write` out 1: memory and IR strobes.
- `reg_write`, `reg_dst`, `mem_to_reg` out 1: register-file write controls. `reg_dst` 1 = rd, 0 = rt.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 0 = register B, 1 = const 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `alu_ctrl` out 4: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- `state` out 4: current state encoding.
- `illegal` out 1: one-cycle pulse on an unsupported instruction.
- `retired_count` out CNT_W: count of completed instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BRANCH=8, JUMP=9.
- FETCH:
  - Asserts `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_ctrl`=add, `pc_source`=0.
  - Asserts `ir_write` and `pc_write` only in the cycle `mem_ready`=1, then moves to DECODE.
  - Holds while `mem_ready`=0.
- DECODE:
  - Sets `alu_src_a`=0, `alu_src_b`=3, `alu_ctrl`=add (branch target to ALUOut).
  - Next state by opcode:
    - 0x23 or 0x2B → MEMADR.
    - 0x00 with a legal funct → RTEXE.
    - 0x04 → BRANCH.
    - 0x02 → JUMP.
    - Anything else → FETCH with `illegal`=1.
  - Legal functs: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct is illegal.
- MEMADR: `alu_src_a`=1, `alu_src_b`=2, `alu_ctrl`=add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Goes to FETCH and retires the instruction.
- MEMWR: `mem_write`=1, `i_or_d`=1. Held until `mem_ready`, then goes to FETCH and retires the instruction.
- RTEXE: `alu_src_a`=1, `alu_src_b`=0, `alu_ctrl` from funct. Goes to RTWB.
- RTWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH and retires the instruction.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_ctrl`=sub, `pc_write_cond`=1, `pc_source`=1. Goes to FETCH and retires the instruction.
- JUMP: `pc_write`=1, `pc_source`=2. Goes to FETCH and retires the instruction.
- Any output not listed for a state is 0.
- `retired_count` increments by 1 on each retire and wraps from 2^CNT_W−1 to 0.
- Illegal instructions are not counted.

## Timing
- Asynchronous reset:
  - `state`=FETCH, `retired_count`=0, `illegal`=0.
  - While `rst`=1, all strobes are forced to 0: `pc_write`, `pc_write_cond`, `mem_read`, `mem_write`, `ir_write`, `reg_write`.
  - While `rst`=1, all selects and `alu_ctrl` are 0.
- Reset deassertion: FETCH outputs appear in the first cycle after release.
- Reset mid-instruction abandons the instruction. No pending write completes and the count is unaffected.
- Output timing:
  - Outputs are Moore decodes of `state`.
  - Exceptions: `alu_ctrl` in RTEXE decodes `funct`; `ir_write`/`pc_write` in FETCH are qualified by `mem_ready`.
  - `illegal` is registered and is high the cycle after DECODE.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles.
  - sw and R-type: 4 cycles.
  - beq and j: 3 cycles.
  - Illegal instruction: 2 cycles.
- Each FETCH, MEMRD, or MEMWR cycle with `mem_ready`=0 adds one cycle.
- `mem_ready` outside those states is ignored.
- A retire and a counter wrap in the same cycle yield 0.

## Configuration
- `MIPS_JUMP_EN`:
  - Defined: opcode 0x02 enters JUMP.
  - Undefined: the JUMP state and `pc_source`=2 are never produced; opcode 0x02 raises `illegal` and returns to FETCH.

## Test plan
- Reset: assert `rst` asynchronously mid-MEMRD. Expect `state`=0 and all strobes 0 immediately, with `retired_count`=0.
- R-type: IR 0x00221820 (add), `mem_ready`=1. Expect states 0,1,6,7,0, `alu_ctrl`=0010 in RTEXE, `reg_write`&`reg_dst` in RTWB, count +1. Repeat with 0x00411822 (sub): `alu_ctrl`=0110.
- Load with wait states: 0x8C240000 (lw), `mem_ready` low for 2 cycles in MEMRD. Expect 7 cycles total, `reg_write`&`mem_to_reg` in MEMWB.
- Store: 0xAC010000 (sw). Expect `mem_write`=1 and `i_or_d`=1 in MEMWR, no `reg_write`, 4 cycles.
- Branch: 0x10210001 (beq) with `zero`=1. Expect `pc_write_cond`=1 and `pc_source`=1 in BRANCH, 3 cycles.
- Illegal instructions:
  - 0x00221821 (bad funct): `illegal` pulses once, `retired_count` unchanged, back to FETCH.
  - 0x08000004 (j): handled by JUMP when `MIPS_JUMP_EN` is defined; flagged illegal when it is undefined.
